// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
//   op_e     - RV32M funct3 encodings
//   state_e  - sequencing FSM states
//   cnt_bits - iteration counter width for a given operand width
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WIDTH_DEFAULT = 32;

  function automatic int cnt_bits(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: shared radix-2 iterative datapath, one bit per step.
//   clk, reset_n  - clock, async active-low reset
//   load          - capture operand magnitudes, clear accumulator high half and counter
//   step          - perform one iteration
//   div           - 1: restoring divide step, 0: shift-add multiply step
//   a_mag, b_mag  - unsigned operand magnitudes
//   acc           - multiply: 2*WIDTH product; divide: {remainder, quotient}
//   last          - current step is the final one
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic               div,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CW = cnt_bits(WIDTH);

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] acc_next;

  assign hi   = acc[2*WIDTH-1:WIDTH];
  assign lo   = acc[WIDTH-1:0];
  assign last = (cnt == CW'(WIDTH - 1));

  // Multiply: the multiplier sits in the low half and is consumed LSB first
  // while the partial product shifts in from the top.
  // Divide: the dividend sits in the low half and is consumed MSB first while
  // quotient bits shift in at the bottom. The partial remainder stays below
  // the divisor, so it always fits back into WIDTH bits.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    if (!div)
      acc_next = {mul_sum, lo[WIDTH-1:1]};
    else if (diff[WIDTH])
      acc_next = {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
    else
      acc_next = {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      opnd <= '0;
      cnt  <= '0;
    end else if (load) begin
      acc  <= {{WIDTH{1'b0}}, a_mag};
      opnd <= b_mag;
      cnt  <= '0;
    end else if (step) begin
      acc  <= acc_next;
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
//   clk, reset_n      - clock, async active-low reset
//   in_valid/in_ready - request handshake (accepted when both high)
//   op                - RV32M funct3
//   read1_data/read2_data - rs1/rs2 operands
//   rd_location       - destination register
//   flush             - abort the in-flight operation
//   busy              - operation in flight
//   write_enabled/write_location/write_data - register-file write port
// Optional: MULDIV_EARLY_OUT_EN lets divide-by-zero, signed overflow and
// rd==0 requests bypass the iterative datapath.
//
// state   | meaning
// IDLE    | ready for a request
// CALC    | WIDTH iterations of the core datapath
// DONE    | sign fix-up, result select, register-file write
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LOC_BITS = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic [WIDTH-1:0]    read1_data,
  input  logic [WIDTH-1:0]    read2_data,
  input  logic [LOC_BITS-1:0] rd_location,
  input  logic                flush,
  output logic                busy,
  output logic                write_enabled,
  output logic [LOC_BITS-1:0] write_location,
  output logic [WIDTH-1:0]    write_data
);

  state_e              state;
  op_e                 op_in;
  op_e                 op_q;
  logic [LOC_BITS-1:0] rd_q;
  logic                s1_q, s2_q, div0_q;
  logic                s1_in, s2_in;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic                accept, step, core_last;
  logic [2*WIDTH-1:0]  core_acc, prod_s;
  logic [WIDTH-1:0]    quot, remd, result;

  assign op_in  = op_e'(op);
  assign accept = (state == ST_IDLE) && in_valid && !flush;
  assign step   = (state == ST_CALC) && !flush;

  // MUL takes unsigned magnitudes: the low half of the product is the same.
  always_comb begin
    s1_in = read1_data[WIDTH-1] && (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    s2_in = read2_data[WIDTH-1] && (op_in inside {OP_MULH, OP_DIV, OP_REM});
    a_mag = s1_in ? -read1_data : read1_data;
    b_mag = s2_in ? -read2_data : read2_data;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic             early_in, early_q;
  logic [WIDTH-1:0] special_in, special_q;

  always_comb begin
    early_in   = (rd_location == '0);
    special_in = '0;
    if (op[2] && read2_data == '0) begin
      early_in   = 1'b1;
      special_in = op[1] ? read1_data : '1;
    end else if (op[2] && !op[0] && read2_data == '1 &&
                 read1_data == {1'b1, {(WIDTH-1){1'b0}}}) begin
      early_in   = 1'b1;
      special_in = op[1] ? '0 : read1_data;
    end
  end
`endif

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .step    (step),
    .div     (op_q[2]),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .acc     (core_acc),
    .last    (core_last)
  );

  // Divide by zero yields all-ones regardless of operand signs, so the
  // quotient negation is suppressed; the remainder path already returns rs1.
  always_comb begin
    quot   = core_acc[WIDTH-1:0];
    remd   = core_acc[2*WIDTH-1:WIDTH];
    prod_s = (s1_q ^ s2_q) ? -core_acc : core_acc;
    case (op_q)
      OP_MUL:                       result = core_acc[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              result = div0_q ? '1 : ((s1_q ^ s2_q) ? -quot : quot);
      default:                      result = s1_q ? -remd : remd;
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    if (early_q) result = special_q;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      op_q           <= OP_MUL;
      rd_q           <= '0;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      div0_q         <= 1'b0;
      in_ready       <= 1'b1;
      busy           <= 1'b0;
      write_enabled  <= 1'b0;
      write_location <= '0;
      write_data     <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      early_q        <= 1'b0;
      special_q      <= '0;
`endif
    end else begin
      write_enabled <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= op_in;
            rd_q     <= rd_location;
            s1_q     <= s1_in;
            s2_q     <= s2_in;
            div0_q   <= op[2] && (read2_data == '0);
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
            early_q   <= early_in;
            special_q <= special_in;
            state     <= early_in ? ST_DONE : ST_CALC;
`else
            state     <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          if (flush) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else if (core_last) begin
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (!flush) begin
            write_enabled  <= (rd_q != '0);
            write_location <= rd_q;
            write_data     <= result;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] read1_data;
  logic [31:0] read2_data;
  logic [4:0]  rd_location;
  logic        flush;
  logic        busy;
  logic        write_enabled;
  logic [4:0]  write_location;
  logic [31:0] write_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .LOC_BITS(5)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .op             (op),
    .read1_data     (read1_data),
    .read2_data     (read2_data),
    .rd_location    (rd_location),
    .flush          (flush),
    .busy           (busy),
    .write_enabled  (write_enabled),
    .write_location (write_location),
    .write_data     (write_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the RV32M arithmetic definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    int          ia, ib;
    longint      sa, sb, ub;
    logic [63:0] p;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ub = {32'b0, b};
    p  = '0;
    case (o)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Rising edges counted from the accept edge (edge 1) until write_enabled is seen high.
  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
`ifdef MULDIV_EARLY_OUT_EN
    if (rd == 0) return 2;
    if (o[2] && b == 0) return 2;
    if (o[2] && !o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`endif
    return 34;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    int          lat, writes, first, bad;
    logic [31:0] exp_d, got_d;
    logic [4:0]  got_loc;
    lat = exp_lat(o, a, b, rd);
    exp_d = ref_result(o, a, b);
    writes = 0; first = 0; bad = 0; got_d = '0; got_loc = '0;
    @(negedge clk);
    check({tag, "_ready_before"}, {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1; op = o; read1_data = a; read2_data = b; rd_location = rd;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      read1_data = $urandom; read2_data = $urandom; rd_location = 5'($urandom);
      if (write_enabled === 1'b1) begin
        writes++;
        if (first == 0) begin first = k; got_d = write_data; got_loc = write_location; end
      end
      if (k < lat && (in_ready !== 1'b0 || busy !== 1'b1)) bad++;
      if (k == lat && (in_ready !== 1'b1 || busy !== 1'b0)) bad++;
    end
    check({tag, "_ready_busy"}, 64'(bad), 64'd0);
    if (rd != 0) begin
      check({tag, "_writes"}, 64'(writes), 64'd1);
      check({tag, "_latency"}, 64'(first), 64'(lat));
      check({tag, "_loc"}, {59'b0, got_loc}, {59'b0, rd});
      check({tag, "_data"}, {32'b0, got_d}, {32'b0, exp_d});
    end else begin
      check({tag, "_no_write"}, 64'(writes), 64'd0);
    end
  endtask

  task automatic watch_no_write(input int n, input string tag);
    int writes;
    writes = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (write_enabled !== 1'b0) writes++;
    end
    check(tag, 64'(writes), 64'd0);
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int          sel;

    reset_n = 1'b0; in_valid = 1'b0; op = '0; read1_data = '0; read2_data = '0;
    rd_location = '0; flush = 1'b0;
    #12;
    check("reset_in_ready", {63'b0, in_ready}, 64'd1);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_we", {63'b0, write_enabled}, 64'd0);
    check("reset_loc", {59'b0, write_location}, 64'd0);
    check("reset_data", {32'b0, write_data}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(3'd0, 32'd6, 32'd7, 5'd5, "mul_6x7");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, "mulh_min");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulhsu_ones");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "mulhu_ones");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, "rem_m7_2");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, "rem_ovf");
    run_op(3'd5, 32'd7, 32'd0, 5'd9, "divu_by0");
    run_op(3'd7, 32'd7, 32'd0, 5'd10, "remu_by0");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd11, "div_neg_by0");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd12, "rem_neg_by0");
    run_op(3'd0, 32'd3, 32'd3, 5'd0, "mul_rd0");

    // Flush during CALC.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; read1_data = 32'd3; read2_data = 32'd3; rd_location = 5'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", {63'b0, in_ready}, 64'd1);
    check("flush_busy", {63'b0, busy}, 64'd0);
    watch_no_write(40, "flush_no_write");

    // Flush together with a request in IDLE.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 3'd5; read1_data = 32'd9; read2_data = 32'd3;
    rd_location = 5'd4;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_ready", {63'b0, in_ready}, 64'd1);
    watch_no_write(40, "idle_flush_no_write");

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd5; read1_data = 32'd100; read2_data = 32'd7; rd_location = 5'd3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    check("areset_ready", {63'b0, in_ready}, 64'd1);
    check("areset_busy", {63'b0, busy}, 64'd0);
    check("areset_loc", {59'b0, write_location}, 64'd0);
    check("areset_data", {32'b0, write_data}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    watch_no_write(40, "areset_no_write");
    run_op(3'd5, 32'd100, 32'd7, 5'd9, "divu_100_7");

    // Randomized operations with edge-case operand injection.
    for (int n = 0; n < 40; n++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) a = 32'($urandom_range(0, 20));
      rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_op(o, a, b, rd, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
